// File: rtl/stream_mux_nto1.sv
// Single-entry registered N-to-1 stream mux with select-mode grant.
// Define STREAM_MUX_RR_EN to replace select mode with round-robin arbitration.
module stream_mux_nto1 #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 32,
  parameter int SEL_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_ch
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_ch;

  logic             w_loadable;
  logic             w_grant_vld;
  logic [SEL_W-1:0] w_grant;
  logic             w_gvalid;
  logic [WIDTH-1:0] w_data;
  logic             w_xfer;

  assign w_loadable = !r_valid || out_ready;

`ifdef STREAM_MUX_RR_EN
  logic [SEL_W-1:0] r_ptr;
  logic             w_unused_sel;

  assign w_unused_sel = ^sel;

  // Search upward from the channel after the last winner, wrapping at NUM_CH.
  always_comb begin
    w_grant     = '0;
    w_grant_vld = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!w_grant_vld && in_valid[(int'(r_ptr) + k) % NUM_CH]) begin
        w_grant_vld = 1'b1;
        w_grant     = SEL_W'((int'(r_ptr) + k) % NUM_CH);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= SEL_W'(NUM_CH - 1);
    end else if (w_xfer) begin
      r_ptr <= w_grant;
    end
  end
`else
  assign w_grant     = sel;
  assign w_grant_vld = ({1'b0, sel} < (SEL_W + 1)'(NUM_CH));
`endif

  always_comb begin
    w_gvalid = 1'b0;
    w_data   = '0;
    in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant == SEL_W'(i)) begin
        w_gvalid    = in_valid[i];
        w_data      = in_data[i*WIDTH +: WIDTH];
        // No handshake may be offered while reset is held.
        in_ready[i] = rst_n && w_grant_vld && w_loadable;
      end
    end
  end

  assign w_xfer = rst_n && w_grant_vld && w_gvalid && w_loadable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_data;
      r_ch    <= w_grant;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_ch    = r_ch;

endmodule

// File: doc/stream_mux_nto1.md
STREAM_MUX_NTO1 -- requirements
Module: stream_mux_nto1

Interface
REQ-001 Parameter WIDTH, default 32: data width per channel in bits; legal range 1..64.
REQ-002 Parameter NUM_CH, default 32: number of input channels; legal range 2..32.
REQ-003 Parameter SEL_W, default 5: select width, equal to ceil(log2(NUM_CH)).
REQ-004 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 Port sel  input  SEL_W: channel select; used in select mode only.
REQ-007 Port in_data  input  NUM_CH*WIDTH: flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port in_valid  input  NUM_CH: per-channel valid.
REQ-009 Port in_ready  output  NUM_CH: per-channel ready, one-hot or all-zero.
REQ-010 Port out_data  output  WIDTH: registered output data.
REQ-011 Port out_valid  output  1: output register holds a word.
REQ-012 Port out_ready  input  1: downstream accepts the word.
REQ-013 Port out_ch  output  SEL_W: registered index of the channel that supplied out_data.

Function
REQ-014 The block SHALL be a single-entry registered stream mux with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- REQ-015 The block SHALL treat the output register as loadable when (!out_valid || out_ready).
- REQ-016 The block SHALL drive in_ready[g]=loadable for the granted channel g only; all other in_ready bits are 0.
- REQ-017 A transfer on channel g SHALL occur when in_valid[g] && in_ready[g]: out_data<=in_data[g], out_ch<=g, out_valid<=1 on the next edge, giving 1-cycle latency.
- REQ-018 FULL with out_ready=1 and no new transfer SHALL go to EMPTY; FULL with out_ready=1 and a transfer SHALL stay FULL with the new word, with no bubble.
- REQ-019 FULL with out_ready=0 SHALL hold out_data, out_ch and out_valid stable regardless of sel or inputs.
- REQ-020 In select mode, sel >= NUM_CH SHALL produce no grant: all in_ready=0 and no load.
- REQ-021 The grant SHALL be combinational from the current-cycle sel/in_valid; a sel change takes effect the same cycle.
- REQ-022 The block SHALL never lose or duplicate a word: each accepted input appears exactly once at the output, in acceptance order.

Reset
REQ-023 Asserting rst_n=0 SHALL immediately clear out_valid=0, out_data=0, out_ch=0 and the round-robin pointer=NUM_CH-1, independent of clk.
REQ-024 Reset mid-operation SHALL discard any held word; no transfer SHALL be signalled while rst_n=0 (in_ready=0).
REQ-025 After rst_n deasserts, the first transfer SHALL occur no earlier than the first rising edge with rst_n=1.

Configuration
REQ-026 Macro STREAM_MUX_RR_EN, when defined, SHALL replace select mode with round-robin arbitration; sel is ignored.
- REQ-027 With STREAM_MUX_RR_EN, the grant SHALL be the first channel with in_valid=1 searching upward, with wrap-around, from pointer+1.
- REQ-028 With STREAM_MUX_RR_EN, the pointer SHALL update to g only on a completed transfer; it SHALL NOT update while stalled.
- REQ-029 Without STREAM_MUX_RR_EN, the grant SHALL be g=sel, asserted only if sel < NUM_CH, and no pointer logic is present.

Verification
REQ-030 Select mode, sel=3, in_valid[3]=1, data 0xA5A5_0003, out_ready=1 -> next cycle out_valid=1, out_data=0xA5A5_0003, out_ch=3.
REQ-031 FULL, out_ready=0 for 4 cycles while sel moves 3->7 -> in_ready=0 throughout and out_data/out_ch unchanged.
- REQ-032 NUM_CH=20, sel=25, all in_valid=1 -> in_ready=0 and out_valid stays 0.
- REQ-033 Continuous in_valid[5], out_ready=1 for 8 cycles -> 8 words out back-to-back, no bubble, in order.
- REQ-034 rst_n pulsed low mid-cycle while FULL -> out_valid/out_data/out_ch drop to 0 before the next edge.
- REQ-035 STREAM_MUX_RR_EN, channels 1, 4 and 30 always valid, out_ready=1 -> out_ch sequence 1,4,30,1,4,30.
